// File: rtl/taint_arb_pkg.sv
// Shared types for the taint-tracked SRAM arbiter: port identifiers and the
// memory request bundle with its bitwise taint twin.
package taint_arb_pkg;

  localparam int NumPorts  = 2;
  localparam int DataWidth = 32;
  localparam int AddrBits  = 15;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_id_e;

  typedef struct packed {
    logic                 we;
    logic [AddrBits-1:0]  addr;
    logic [DataWidth-1:0] wdata;
    logic [DataWidth-1:0] strb;
  } mem_req_t;

  typedef struct packed {
    logic                 we;
    logic [AddrBits-1:0]  addr;
    logic [DataWidth-1:0] wdata;
    logic [DataWidth-1:0] strb;
  } mem_req_t0_t;

endpackage

// File: rtl/taint_rr_prio.sv
// Winner selection between instruction and data ports with a starvation
// guard for port 0, plus the taint of the selection decision itself.
module taint_rr_prio
  import taint_arb_pkg::*;
#(
  parameter int MaxStarve = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] req_i_t0,
  output port_id_e   winner_o,
  output logic       sel_t0_o
);

  localparam logic [3:0] MaxCnt = 4'(MaxStarve);

  logic [3:0] cnt_q, cnt_d;
  logic       cnt_t0_q;

  // Port 1 wins contention unless port 0 has lost MaxStarve times in a row.
  always_comb begin
    winner_o = PORT_INSTR;
    if (req_i[1] && !(req_i[0] && cnt_q == MaxCnt)) begin
      winner_o = PORT_DATA;
    end
    cnt_d = cnt_q;
    if (!req_i[0] || winner_o == PORT_INSTR) begin
      cnt_d = '0;
    end else if (cnt_q != MaxCnt) begin
      cnt_d = cnt_q + 4'd1;
    end
    sel_t0_o = req_i_t0[0] | req_i_t0[1] | cnt_t0_q;
  end

  // Counter taint is sticky: once a tainted decision moved it, it stays tainted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      cnt_t0_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (sel_t0_o && cnt_d != cnt_q) begin
        cnt_t0_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/taint_sram_arbiter.sv
// Shares one taint-tracked single-port SRAM between instruction fetch (port 0)
// and data access (port 1), routing the 1-cycle read response to the winner.
module taint_sram_arbiter
  import taint_arb_pkg::*;
#(
  parameter int Width     = 32,
  parameter int AddrWidth = 15,
  parameter int NumTaints = 1,
  parameter int MaxStarve = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_i,
  input  logic [1:0]                we_i,
  input  logic [1:0][AddrWidth-1:0] addr_i,
  input  logic [1:0][Width-1:0]     wdata_i,
  input  logic [1:0][Width-1:0]     strb_i,
  output logic [1:0]                gnt_o,
  output logic [1:0]                rvalid_o,
  output logic [Width-1:0]          rdata_o,
  input  logic [1:0]                req_i_t0,
  input  logic [1:0]                we_i_t0,
  input  logic [1:0][AddrWidth-1:0] addr_i_t0,
  input  logic [1:0][Width-1:0]     wdata_i_t0,
  input  logic [1:0][Width-1:0]     strb_i_t0,
  output logic [1:0]                gnt_o_t0,
  output logic [1:0]                rvalid_o_t0,
  output logic [Width-1:0]          rdata_o_t0,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [AddrWidth-1:0]      mem_addr_o,
  output logic [Width-1:0]          mem_wdata_o,
  output logic [Width-1:0]          mem_strb_o,
  input  logic [Width-1:0]          mem_rdata_i,
  output logic                      mem_req_o_t0,
  output logic                      mem_we_o_t0,
  output logic [AddrWidth-1:0]      mem_addr_o_t0,
  output logic [Width-1:0]          mem_wdata_o_t0,
  output logic [Width-1:0]          mem_strb_o_t0,
  input  logic [Width-1:0]          mem_rdata_i_t0
);

  localparam int ReqBits = $bits(mem_req_t);

  if (NumTaints != 1) begin : g_bad_taints
    $error("taint_sram_arbiter supports exactly one taint colour");
  end
  if (MaxStarve < 1 || MaxStarve > 15) begin : g_bad_starve
    $error("taint_sram_arbiter MaxStarve must be within 1..15");
  end
  if (Width != DataWidth || AddrWidth != AddrBits) begin : g_bad_width
    $error("taint_sram_arbiter widths must match taint_arb_pkg");
  end

  port_id_e                   winner;
  logic                       sel_t0;
  mem_req_t    [NumPorts-1:0] port_req;
  mem_req_t0_t [NumPorts-1:0] port_t0;
  mem_req_t                   win_req;
  mem_req_t0_t                win_t0;
  logic        [ReqBits-1:0]  diff;

  logic     resp_pending, was_write, owner_t0, sel_q, rvalid;
  port_id_e owner;
  logic [1:0] gnt_t0_q;

  taint_rr_prio #(.MaxStarve(MaxStarve)) u_prio (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .req_i_t0 (req_i_t0),
    .winner_o (winner),
    .sel_t0_o (sel_t0)
  );

  // A field bit that differs between the ports inherits the selection taint.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      port_req[i] = '{we: we_i[i], addr: addr_i[i], wdata: wdata_i[i], strb: strb_i[i]};
      port_t0[i]  = '{we: we_i_t0[i], addr: addr_i_t0[i], wdata: wdata_i_t0[i],
                      strb: strb_i_t0[i]};
    end
    win_req = port_req[winner];
    diff    = port_req[0] ^ port_req[1];
    win_t0  = port_t0[winner] | (diff & {ReqBits{sel_t0}});
  end

  assign gnt_o     = ((winner == PORT_DATA) ? 2'b10 : 2'b01) & req_i;
  assign gnt_o_t0  = {2{sel_t0}} | req_i_t0;
  assign mem_req_o = |req_i;
  assign mem_req_o_t0 = (&req_i_t0) | (req_i_t0[0] & ~req_i[1]) | (req_i_t0[1] & ~req_i[0]);
  assign {mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o} = win_req;
  assign {mem_we_o_t0, mem_addr_o_t0, mem_wdata_o_t0, mem_strb_o_t0} = win_t0;

  // Response bookkeeping; a reset in the response cycle drops the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_pending <= 1'b0;
      was_write    <= 1'b0;
      owner        <= PORT_INSTR;
      owner_t0     <= 1'b0;
      sel_q        <= 1'b0;
      gnt_t0_q     <= '0;
    end else begin
      resp_pending <= |gnt_o;
      sel_q        <= sel_t0;
      gnt_t0_q     <= gnt_o_t0;
      if (|gnt_o) begin
        owner     <= winner;
        was_write <= win_req.we;
        owner_t0  <= sel_t0;
      end
    end
  end

  assign rvalid      = resp_pending & ~was_write & ~rst_i;
  assign rvalid_o    = (owner == PORT_DATA) ? {rvalid, 1'b0} : {1'b0, rvalid};
  assign rdata_o     = rvalid ? mem_rdata_i : '0;
  assign rvalid_o_t0 = ({2{sel_q}} | gnt_t0_q) & {2{~rst_i}};
  assign rdata_o_t0  = (mem_rdata_i_t0 | {Width{owner_t0}}) & {Width{~rst_i}};

endmodule

// File: tb/tb_taint_sram_arbiter.sv
// Directed self-checking bench for taint_sram_arbiter with a small strobed
// SRAM model attached to the memory side.
module tb_taint_sram_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        req_i, we_i, req_i_t0, we_i_t0;
  logic [1:0][14:0]  addr_i, addr_i_t0;
  logic [1:0][31:0]  wdata_i, strb_i, wdata_i_t0, strb_i_t0;
  logic [1:0]        gnt_o, rvalid_o, gnt_o_t0, rvalid_o_t0;
  logic [31:0]       rdata_o, rdata_o_t0;
  logic              mem_req_o, mem_we_o, mem_req_o_t0, mem_we_o_t0;
  logic [14:0]       mem_addr_o, mem_addr_o_t0;
  logic [31:0]       mem_wdata_o, mem_strb_o, mem_wdata_o_t0, mem_strb_o_t0;
  logic [31:0]       mem_rdata_i, mem_rdata_i_t0;
  logic [31:0]       mem [32];
  int                n_cmp = 0;
  int                n_fail = 0;

  always #5 clk_i = ~clk_i;

  taint_sram_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .req_i_t0(req_i_t0), .we_i_t0(we_i_t0), .addr_i_t0(addr_i_t0),
    .wdata_i_t0(wdata_i_t0), .strb_i_t0(strb_i_t0), .gnt_o_t0(gnt_o_t0),
    .rvalid_o_t0(rvalid_o_t0), .rdata_o_t0(rdata_o_t0), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_strb_o(mem_strb_o), .mem_rdata_i(mem_rdata_i), .mem_req_o_t0(mem_req_o_t0),
    .mem_we_o_t0(mem_we_o_t0), .mem_addr_o_t0(mem_addr_o_t0),
    .mem_wdata_o_t0(mem_wdata_o_t0), .mem_strb_o_t0(mem_strb_o_t0),
    .mem_rdata_i_t0(mem_rdata_i_t0)
  );

  // SRAM model: strobed writes, one-cycle read latency.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) mem[mem_addr_o[4:0]] <= (mem[mem_addr_o[4:0]] & ~mem_strb_o) | (mem_wdata_o & mem_strb_o);
      else mem_rdata_i <= mem[mem_addr_o[4:0]];
    end
  end

  task automatic drive_idle();
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; strb_i = '0;
    req_i_t0 = '0; we_i_t0 = '0; addr_i_t0 = '0; wdata_i_t0 = '0; strb_i_t0 = '0;
    mem_rdata_i_t0 = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (gnt_o !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt_o); end
    n_cmp++; if (rvalid_o !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rvalid: got %b expected 00", rvalid_o); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req_o); end
    n_cmp++; if ({gnt_o_t0, rvalid_o_t0, mem_req_o_t0} !== 5'b0) begin n_fail++;
      $display("[TB] FAIL reset_taints: got %b expected 00000", {gnt_o_t0, rvalid_o_t0, mem_req_o_t0}); end
    n_cmp++; if (rdata_o_t0 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata_t0: got %h expected 0", rdata_o_t0); end
    @(negedge clk_i);
  endtask

  task automatic test_single_read();
    do_reset();
    req_i = 2'b01; addr_i[0] = 15'h10;
    #1;
    n_cmp++; if (gnt_o !== 2'b01) begin n_fail++; $display("[TB] FAIL read_gnt: got %b expected 01", gnt_o); end
    n_cmp++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0) begin n_fail++;
      $display("[TB] FAIL read_mem_ctl: got req=%b we=%b expected req=1 we=0", mem_req_o, mem_we_o); end
    n_cmp++; if (mem_addr_o !== 15'h10) begin n_fail++; $display("[TB] FAIL read_mem_addr: got %h expected 0010", mem_addr_o); end
    @(negedge clk_i);
    drive_idle();
    #1;
    n_cmp++; if (rvalid_o !== 2'b01) begin n_fail++; $display("[TB] FAIL read_rvalid: got %b expected 01", rvalid_o); end
    n_cmp++; if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL read_rdata: got %h expected deadbeef", rdata_o); end
    n_cmp++; if (rvalid_o_t0 !== 2'b00 || rdata_o_t0 !== 32'h0) begin n_fail++;
      $display("[TB] FAIL read_untainted: got rvalid_t0=%b rdata_t0=%h expected 00/0", rvalid_o_t0, rdata_o_t0); end
    @(negedge clk_i);
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt, prev_gnt;
    logic [14:0] exp_addr;
    do_reset();
    req_i = 2'b11; addr_i[0] = 15'h2; addr_i[1] = 15'h1;
    prev_gnt = 2'b00;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_gnt  = (k % 5 == 4) ? 2'b01 : 2'b10;
      exp_addr = (k % 5 == 4) ? 15'h2 : 15'h1;
      n_cmp++; if (gnt_o !== exp_gnt) begin n_fail++; $display("[TB] FAIL starve_gnt[%0d]: got %b expected %b", k, gnt_o, exp_gnt); end
      n_cmp++; if (mem_addr_o !== exp_addr) begin n_fail++;
        $display("[TB] FAIL starve_addr[%0d]: got %h expected %h", k, mem_addr_o, exp_addr); end
      n_cmp++; if (mem_addr_o_t0 !== 15'h0) begin n_fail++;
        $display("[TB] FAIL starve_addr_t0[%0d]: got %h expected 0000", k, mem_addr_o_t0); end
      if (k > 0) begin
        n_cmp++; if (rvalid_o !== prev_gnt) begin n_fail++;
          $display("[TB] FAIL starve_rvalid[%0d]: got %b expected %b", k, rvalid_o, prev_gnt); end
      end
      prev_gnt = exp_gnt;
      @(negedge clk_i);
    end
    drive_idle();
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_i = 2'b10; we_i = 2'b10; addr_i[1] = 15'h3; wdata_i[1] = 32'h5A5A5A5A; strb_i[1] = 32'h0000FFFF;
    #1;
    n_cmp++; if (gnt_o !== 2'b10 || mem_we_o !== 1'b1) begin n_fail++;
      $display("[TB] FAIL wr_gnt: got gnt=%b we=%b expected 10/1", gnt_o, mem_we_o); end
    n_cmp++; if (mem_strb_o !== 32'h0000FFFF) begin n_fail++; $display("[TB] FAIL wr_strb: got %h expected 0000ffff", mem_strb_o); end
    @(negedge clk_i);
    we_i = 2'b00;
    #1;
    n_cmp++; if (rvalid_o !== 2'b00) begin n_fail++; $display("[TB] FAIL wr_no_rvalid: got %b expected 00", rvalid_o); end
    n_cmp++; if (gnt_o !== 2'b10) begin n_fail++; $display("[TB] FAIL rd_gnt: got %b expected 10", gnt_o); end
    @(negedge clk_i);
    drive_idle();
    #1;
    n_cmp++; if (rvalid_o !== 2'b10) begin n_fail++; $display("[TB] FAIL rd_rvalid: got %b expected 10", rvalid_o); end
    n_cmp++; if (rdata_o !== 32'h00005A5A) begin n_fail++; $display("[TB] FAIL rd_rdata: got %h expected 00005a5a", rdata_o); end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i = 2'b10; addr_i[1] = 15'h3;
    #1;
    n_cmp++; if (gnt_o !== 2'b10) begin n_fail++; $display("[TB] FAIL mid_gnt: got %b expected 10", gnt_o); end
    @(negedge clk_i);
    drive_idle();
    rst_i = 1'b1;
    #1;
    n_cmp++; if (rvalid_o !== 2'b00 || rdata_o !== 32'h0) begin n_fail++;
      $display("[TB] FAIL mid_drop: got rvalid=%b rdata=%h expected 00/0", rvalid_o, rdata_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_cmp++; if (rvalid_o !== 2'b00 || rdata_o !== 32'h0) begin n_fail++;
      $display("[TB] FAIL mid_after: got rvalid=%b rdata=%h expected 00/0", rvalid_o, rdata_o); end
    @(negedge clk_i);
  endtask

  task automatic test_taint();
    do_reset();
    req_i = 2'b11; req_i_t0 = 2'b10; addr_i[0] = 15'h10; addr_i[1] = 15'h3;
    #1;
    n_cmp++; if (gnt_o_t0 !== 2'b11) begin n_fail++; $display("[TB] FAIL taint_gnt_t0: got %b expected 11", gnt_o_t0); end
    n_cmp++; if (mem_addr_o_t0 !== 15'h13) begin n_fail++; $display("[TB] FAIL taint_addr_t0: got %h expected 0013", mem_addr_o_t0); end
    n_cmp++; if (mem_req_o_t0 !== 1'b0 || mem_we_o_t0 !== 1'b0) begin n_fail++;
      $display("[TB] FAIL taint_req_we_t0: got %b%b expected 00", mem_req_o_t0, mem_we_o_t0); end
    @(negedge clk_i);
    drive_idle();
    #1;
    n_cmp++; if (rvalid_o !== 2'b10 || rvalid_o_t0[1] !== 1'b1) begin n_fail++;
      $display("[TB] FAIL taint_rvalid_t0: got rvalid=%b rvalid_t0=%b expected 10/1x", rvalid_o, rvalid_o_t0); end
    n_cmp++; if (rdata_o_t0 !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL taint_owner_rdata_t0: got %h expected ffffffff", rdata_o_t0); end
    do_reset();
    req_i = 2'b01; req_i_t0 = 2'b01;
    #1;
    n_cmp++; if (mem_req_o_t0 !== 1'b1 || gnt_o_t0 !== 2'b11) begin n_fail++;
      $display("[TB] FAIL taint_single_req_t0: got req_t0=%b gnt_t0=%b expected 1/11", mem_req_o_t0, gnt_o_t0); end
    do_reset();
    req_i = 2'b01; addr_i[0] = 15'h10;
    #1;
    n_cmp++; if (gnt_o_t0 !== 2'b00) begin n_fail++; $display("[TB] FAIL clean_gnt_t0: got %b expected 00", gnt_o_t0); end
    @(negedge clk_i);
    drive_idle();
    mem_rdata_i_t0 = 32'h000000FF;
    #1;
    n_cmp++; if (rdata_o_t0 !== 32'h000000FF) begin n_fail++; $display("[TB] FAIL clean_rdata_t0: got %h expected 000000ff", rdata_o_t0); end
    @(negedge clk_i);
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[16] = 32'hDEADBEEF;
    mem_rdata_i = 32'h0;
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_taint();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
